// File: rtl/serial_adder_seq_pkg.sv
// Shared definitions for digit-serial arithmetic blocks: FSM state encoding
// and digit-count / counter-width derivation.
package serial_adder_seq_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int numDigits(input int width, input int dw);
        return width / dw;
    endfunction

    // A one-digit operation still needs a one-bit counter to stay legal.
    function automatic int ctrWidth(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_seq_if.sv
// Operand/result handshake bundle for serial_adder_seq.
interface serial_adder_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder_seq_digit_adder.sv
// Combinational DW-bit ripple-carry digit adder; cmsb is the carry into the
// digit's top bit, needed for signed-overflow detection on the last digit.
module digit_adder #(
    parameter int DW = 1
) (
    output logic [DW-1:0] sum,
    output logic          cout,
    output logic          cmsb,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          cin
);
    logic [DW:0] carry;

    assign carry[0] = cin;

    for (genvar gi = 0; gi < DW; gi++) begin : g_fa
        assign sum[gi]      = a[gi] ^ b[gi] ^ carry[gi];
        assign carry[gi+1]  = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end

    assign cout = carry[DW];
    assign cmsb = carry[DW-1];
endmodule

// File: rtl/serial_adder_seq.sv
// Digit-serial adder/subtractor: WIDTH-bit operands consumed DW bits per clock,
// inter-digit carry kept in a flip-flop, valid/ready on both sides.
module serial_adder_seq
    import serial_adder_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DW    = 1
) (
    input  logic              clk,
    input  logic              rst,
    serial_adder_seq_if.slave bus
);
    localparam int NDIG = numDigits(WIDTH, DW);
    localparam int CW   = ctrWidth(NDIG);
    localparam logic [CW-1:0] LAST_DIGIT = CW'(NDIG - 1);

    logic [1:0]       stateReg;
    logic [WIDTH-1:0] opAReg;
    logic [WIDTH-1:0] opBReg;
    logic             carryReg;
    logic [CW-1:0]    digitReg;
    logic [WIDTH-1:0] sumReg;
    logic             coutReg;
    logic             ovfReg;

    logic [DW-1:0]    digitSum;
    logic             digitCout;
    logic             digitCmsb;
    logic [WIDTH-1:0] sumNext;

    // Operands shift right so the active digit always sits in the low DW bits.
    digit_adder #(.DW(DW)) u_digit (
        .sum  (digitSum),
        .cout (digitCout),
        .cmsb (digitCmsb),
        .a    (opAReg[DW-1:0]),
        .b    (opBReg[DW-1:0]),
        .cin  (carryReg)
    );

    // Result digits enter from the top; after NDIG digits digit 0 lands at bit 0.
    if (NDIG == 1) begin : g_single
        assign sumNext = digitSum;
    end else begin : g_multi
        assign sumNext = {digitSum, sumReg[WIDTH-1:DW]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg <= ST_IDLE;
            opAReg   <= '0;
            opBReg   <= '0;
            carryReg <= 1'b0;
            digitReg <= '0;
            sumReg   <= '0;
            coutReg  <= 1'b0;
            ovfReg   <= 1'b0;
        end else begin
            case (stateReg)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        opAReg   <= bus.a;
                        opBReg   <= bus.b ^ {WIDTH{bus.sub}};
                        carryReg <= bus.sub ? 1'b1 : bus.cin;
                        digitReg <= '0;
                        stateReg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    opAReg   <= opAReg >> DW;
                    opBReg   <= opBReg >> DW;
                    sumReg   <= sumNext;
                    carryReg <= digitCout;
                    digitReg <= digitReg + 1'b1;
                    if (digitReg == LAST_DIGIT) begin
                        coutReg  <= digitCout;
                        ovfReg   <= digitCmsb ^ digitCout;
                        stateReg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        stateReg <= ST_IDLE;
                    end
                end
                default: stateReg <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (stateReg == ST_IDLE);
    assign bus.out_valid = (stateReg == ST_DONE);
    assign bus.sum       = sumReg;
    assign bus.cout      = coutReg;
    assign bus.ovf       = ovfReg;
endmodule
